serial_msb_transmitter: RTL and testbench

Parallel-to-serial transmitter that produces the MSB-first bit streams consumed by our serial divisibility checkers. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock with framing strobes. In parallel it tracks the running residue of the transmitted prefix modulo MOD and drives a registered expected-divisibility flag. That flag is cycle-aligned with a checker's registered output so a bench or self-test wrapper can compare the two directly.

---
 rtl/serial_msb_transmitter_pkg.sv | 23 ++
 rtl/serial_msb_transmitter_residue_tracker.sv | 55 +++++
 rtl/serial_msb_transmitter.sv | 125 ++++++++++++
 tb/tb_serial_msb_transmitter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_msb_transmitter_pkg.sv
// Shared definitions for the MSB-first serial transmitter and its residue tracker.
package serial_msb_transmitter_pkg;

  // Transmitter state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Width of a residue modulo 'modulus'
  function automatic int calc_rw(input int modulus);
    return $clog2(modulus);
  endfunction

  // Fold one more MSB-first bit into residue r: (2r + b) mod modulus.
  // With r < modulus, 2r + b < 2*modulus, so one conditional subtract is enough.
  function automatic logic [31:0] mod_step(input logic [31:0] r, input logic b,
                                           input logic [31:0] modulus);
    logic [31:0] t;
    t = {r[30:0], 1'b0} + {31'd0, b};
    return (t >= modulus) ? (t - modulus) : t;
  endfunction

endpackage

// File: rtl/serial_msb_transmitter_residue_tracker.sv
// Running residue of an MSB-first bit stream modulo MOD, with a registered zero flag.
module residue_tracker
  import serial_msb_transmitter_pkg::*;
#(
  parameter int MOD = 3,
  localparam int RW = calc_rw(MOD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          first,
  input  logic          bit_in,
  input  logic          clr,
  output logic [RW-1:0] res,
  output logic          is_zero
);

  logic [RW-1:0] res_q;
  logic [RW-1:0] res_d;
  logic          is_zero_q;
  logic          is_zero_d;
  logic [31:0]   step_s;

  // Next residue: clear wins, the first bit restarts from 0, otherwise hold
  always_comb begin
    step_s    = mod_step(first ? 32'd0 : 32'(res_q), bit_in, 32'(MOD));
    res_d     = res_q;
    is_zero_d = is_zero_q;
    if (clr) begin
      res_d     = '0;
      is_zero_d = 1'b0;
    end else if (en) begin
      res_d     = RW'(step_s);
      is_zero_d = (step_s == 32'd0);
    end else begin
      res_d     = res_q;
      is_zero_d = is_zero_q;
    end
  end

  // Residue and flag registers; the flag resets low even though the residue is 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q     <= '0;
      is_zero_q <= 1'b0;
    end else begin
      res_q     <= res_d;
      is_zero_q <= is_zero_d;
    end
  end

  assign res     = res_q;
  assign is_zero = is_zero_q;

endmodule

// File: rtl/serial_msb_transmitter.sv
// Parallel-to-serial MSB-first transmitter with framing strobes and an
// expected-divisibility flag aligned to a checker's registered output.
module serial_msb_transmitter
  import serial_msb_transmitter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MOD   = 3,
  parameter int GAP   = 1,
  localparam int RW   = calc_rw(MOD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             abort,
  output logic             out,
  output logic             bit_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy,
  output logic [RW-1:0]    exp_res,
  output logic             exp_div
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic          HANDOFF  = (GAP == 0) ? 1'b1 : 1'b0;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             load_fire_s;

  // State, bit counter, gap counter and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state: load on handshake, shift WIDTH bits, optional gap, abort to IDLE
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gcnt_d      = gcnt_q;
    shreg_d     = shreg_q;
    load_fire_s = load_valid & load_ready;
    case (state_q)
      ST_IDLE: begin
        if (load_fire_s) begin
          shreg_d = load_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          if (load_fire_s) begin
            // Back-to-back handoff: next word's sof follows this eof directly
            shreg_d = load_data;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end else if (GAP > 0) begin
            gcnt_d  = '0;
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state; abort in the eof cycle refuses the handoff
  always_comb begin
    bit_valid  = (state_q == ST_SHIFT);
    out        = bit_valid & shreg_q[WIDTH-1];
    sof        = bit_valid & (cnt_q == '0);
    eof        = bit_valid & (cnt_q == CNT_LAST);
    busy       = (state_q != ST_IDLE);
    load_ready = (state_q == ST_IDLE) | (HANDOFF & eof & ~abort);
  end

  residue_tracker #(.MOD(MOD)) u_residue (
    .clk     (clk),
    .reset   (reset),
    .en      (bit_valid),
    .first   (sof),
    .bit_in  (out),
    .clr     (bit_valid & abort),
    .res     (exp_res),
    .is_zero (exp_div)
  );

endmodule

// File: tb/tb_serial_msb_transmitter.sv
// Scoreboard bench: one transmitter with GAP=0 (a_*) and one with GAP=2 (b_*).
module tb_serial_msb_transmitter;

  typedef struct {
    logic       o;
    logic       s;
    logic       e;
    logic [1:0] r;
  } exp_t;

  logic clk;
  logic reset;
  logic a_load_valid, a_load_ready, a_abort, a_out, a_bit_valid, a_sof, a_eof, a_busy, a_exp_div;
  logic [7:0] a_load_data;
  logic [1:0] a_exp_res;
  logic b_load_valid, b_load_ready, b_abort, b_out, b_bit_valid, b_sof, b_eof, b_busy, b_exp_div;
  logic [7:0] b_load_data;
  logic [1:0] b_exp_res;

  logic sel;
  logic mon_en;
  logic m_out, m_bit_valid, m_sof, m_eof, m_exp_div, m_load_ready;
  logic [1:0] m_exp_res;

  exp_t sbq[$];
  logic pend_valid;
  logic [1:0] pend_r;
  int checks;
  int errors;

  serial_msb_transmitter #(.WIDTH(8), .MOD(3), .GAP(0)) dut_a (
    .clk(clk), .reset(reset), .load_valid(a_load_valid), .load_ready(a_load_ready),
    .load_data(a_load_data), .abort(a_abort), .out(a_out), .bit_valid(a_bit_valid),
    .sof(a_sof), .eof(a_eof), .busy(a_busy), .exp_res(a_exp_res), .exp_div(a_exp_div)
  );

  serial_msb_transmitter #(.WIDTH(8), .MOD(3), .GAP(2)) dut_b (
    .clk(clk), .reset(reset), .load_valid(b_load_valid), .load_ready(b_load_ready),
    .load_data(b_load_data), .abort(b_abort), .out(b_out), .bit_valid(b_bit_valid),
    .sof(b_sof), .eof(b_eof), .busy(b_busy), .exp_res(b_exp_res), .exp_div(b_exp_div)
  );

  assign m_out        = sel ? b_out        : a_out;
  assign m_bit_valid  = sel ? b_bit_valid  : a_bit_valid;
  assign m_sof        = sel ? b_sof        : a_sof;
  assign m_eof        = sel ? b_eof        : a_eof;
  assign m_exp_res    = sel ? b_exp_res    : a_exp_res;
  assign m_exp_div    = sel ? b_exp_div    : a_exp_div;
  assign m_load_ready = sel ? b_load_ready : a_load_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: residue by true modulo, restarting at every word
  task automatic push_word(input logic [7:0] d);
    int r;
    exp_t e;
    r = 0;
    for (int i = 0; i < 8; i++) begin
      e.o = d[7-i];
      e.s = (i == 0);
      e.e = (i == 7);
      r = (2 * r + int'(e.o)) % 3;
      e.r = 2'(r);
      sbq.push_back(e);
    end
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    if (sel) begin
      b_load_valid = 1'b1; b_load_data = d;
    end else begin
      a_load_valid = 1'b1; a_load_data = d;
    end
    @(negedge clk);
    while (!m_load_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("send_ready", m_load_ready, 1'b1);
    push_word(d);
    @(posedge clk); #1;
    a_load_valid = 1'b0;
    b_load_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sbq.size() != 0 || m_bit_valid || pend_valid) && n < 60) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    check(tag, sbq.size(), 0);
  endtask

  // Monitor: pop one expected bit per bit_valid cycle, check residue one cycle later
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        pend_valid = 1'b0;
      end else begin
        if (pend_valid) begin
          check("exp_res", m_exp_res, pend_r);
          check("exp_div", m_exp_div, (pend_r == 2'd0));
          pend_valid = 1'b0;
        end
        if (m_bit_valid) begin
          if (sbq.size() == 0) begin
            check("unexpected_bit", 1'b1, 1'b0);
          end else begin
            e = sbq.pop_front();
            check("out", m_out, e.o);
            check("sof", m_sof, e.s);
            check("eof", m_eof, e.e);
            pend_r = e.r;
            pend_valid = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int sof_c[2];
    int eof_c, nsof, neof, ngap, nidle, nhs;
    checks = 0; errors = 0;
    sel = 1'b0; mon_en = 1'b0; pend_valid = 1'b0; pend_r = 2'd0;
    a_load_valid = 1'b0; a_load_data = 8'h00; a_abort = 1'b0;
    b_load_valid = 1'b0; b_load_data = 8'h00; b_abort = 1'b0;
    reset = 1'b1;

    // Reset state
    #3;
    check("rst_out", a_out, 1'b0);
    check("rst_bv", a_bit_valid, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_res", a_exp_res, 2'd0);
    check("rst_div", a_exp_div, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", a_load_ready, 1'b1);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Test 1: 0xB4, sof one cycle after the handshake
    send(8'hB4);
    @(negedge clk);
    check("t1_sof_lat", a_sof, 1'b1);
    wait_drain("t1_drain");

    // Test 2: back-to-back 0xFF then 0x00 on the GAP=0 unit
    @(posedge clk); #1;
    a_load_valid = 1'b1; a_load_data = 8'hFF;
    @(negedge clk);
    check("t2_ready0", a_load_ready, 1'b1);
    push_word(8'hFF);
    @(posedge clk); #1;
    a_load_data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("t2_bv", a_bit_valid, 1'b1);
      if (i == 7) begin
        check("t2_eof_ready", a_load_ready, 1'b1);
        push_word(8'h00);
      end
      if (i == 8) check("t2_sof2", a_sof, 1'b1);
      @(posedge clk); #1;
      if (i == 7) a_load_valid = 1'b0;
    end
    @(negedge clk);
    check("t2_end_bv", a_bit_valid, 1'b0);
    wait_drain("t2_drain");

    // Test 3: GAP=2 unit with load_valid held for two words
    sel = 1'b1;
    @(posedge clk); #1;
    b_load_valid = 1'b1; b_load_data = 8'h3C;
    nsof = 0; neof = 0; ngap = 0; nidle = 0; nhs = 0; eof_c = 0;
    sof_c[0] = 0; sof_c[1] = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (b_sof && nsof < 2) begin sof_c[nsof] = c; nsof++; end
      if (b_eof && neof == 0) begin eof_c = c; neof = 1; end
      if (nsof == 1 && neof == 1 && b_busy && !b_bit_valid) begin
        ngap++;
        check("t3_gap_ready", b_load_ready, 1'b0);
      end
      if (nsof == 1 && neof == 1 && !b_busy) nidle++;
      if (b_load_valid && b_load_ready) begin push_word(b_load_data); nhs++; end
      @(posedge clk); #1;
      if (nhs == 1) b_load_data = 8'h5A;
      if (nhs >= 2) b_load_valid = 1'b0;
      if (nsof == 2) break;
    end
    b_load_valid = 1'b0;
    check("t3_nsof", nsof, 2);
    check("t3_sof_dist", sof_c[1] - eof_c, 4);
    check("t3_ngap", ngap, 2);
    check("t3_nidle", nidle, 1);
    wait_drain("t3_drain");

    // Test 4: load_data/load_valid wiggle during 0xA5 must not disturb it
    send(8'hA5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_ready", b_load_ready, 1'b0);
      @(posedge clk); #1;
      b_load_data = 8'($urandom_range(0, 255));
      b_load_valid = (i % 2 == 0);
    end
    b_load_valid = 1'b0;
    wait_drain("t4_drain");
    sel = 1'b0;

    // Test 5: abort during the 4th bit of 0xC3
    mon_en = 1'b0;
    send(8'hC3);
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    a_abort = 1'b1;
    @(negedge clk);
    check("t5_bv_at_abort", a_bit_valid, 1'b1);
    check("t5_div_before", a_exp_div, 1'b1);
    @(posedge clk); #1;
    a_abort = 1'b0;
    @(negedge clk);
    check("t5_bv", a_bit_valid, 1'b0);
    check("t5_eof", a_eof, 1'b0);
    check("t5_res", a_exp_res, 2'd0);
    check("t5_div", a_exp_div, 1'b0);
    check("t5_ready", a_load_ready, 1'b1);
    sbq.delete();

    // Abort coinciding with eof: handoff refused, residue cleared
    @(posedge clk); #1;
    send(8'h00);
    for (int i = 0; i < 7; i++) begin @(posedge clk); #1; end
    a_abort = 1'b1; a_load_valid = 1'b1; a_load_data = 8'hFF;
    @(negedge clk);
    check("ae_eof", a_eof, 1'b1);
    check("ae_ready", a_load_ready, 1'b0);
    @(posedge clk); #1;
    a_abort = 1'b0; a_load_valid = 1'b0;
    @(negedge clk);
    check("ae_bv", a_bit_valid, 1'b0);
    check("ae_busy", a_busy, 1'b0);
    check("ae_div", a_exp_div, 1'b0);
    sbq.delete();

    // Test 6: asynchronous reset mid-word, then a clean 0x81
    @(posedge clk); #1;
    send(8'hFF);
    for (int i = 0; i < 2; i++) begin @(posedge clk); #1; end
    #2;
    reset = 1'b1;
    #1;
    check("t6_out", a_out, 1'b0);
    check("t6_bv", a_bit_valid, 1'b0);
    check("t6_busy", a_busy, 1'b0);
    check("t6_div", a_exp_div, 1'b0);
    sbq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_idle_bv", a_bit_valid, 1'b0);
    check("t6_ready", a_load_ready, 1'b1);
    @(posedge clk); #1;
    mon_en = 1'b1;
    send(8'h81);
    wait_drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
